// File: rtl/result_display_pkg.sv
// Shared constants for result_display: 7-segment glyphs (active-low, g..a),
// IEEE-754 single field positions and a small float classifier.
`timescale 1ns/1ps
package result_display_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Text glyphs; lowercase n lights c, e and g.
    localparam logic [6:0] BLANK   = 7'h7F;
    localparam logic [6:0] DASH    = 7'h3F;
    localparam logic [6:0] GLYPH_I = 7'h79;
    localparam logic [6:0] GLYPH_n = 7'h2B;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'd0,
        FP_INF    = 2'd1,
        FP_NAN    = 2'd2
    } fp_class_e;

    function automatic fp_class_e fp_classify(input logic [31:0] w);
        if (w[EXP_MSB:EXP_LSB] != 8'hFF) begin
            return FP_NORMAL;
        end else if (w[MANT_W-1:0] != '0) begin
            return FP_NAN;
        end else begin
            return FP_INF;
        end
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern (seg[6:0] = g f e d c b a).
`timescale 1ns/1ps
module seg_hex_decode
    import result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = BLANK;
        case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Result queue feeding a multiplexed 8-digit active-low 7-segment display.
// Define FLOAT_SPECIAL_TEXT_EN to render IEEE-754 NaN/Inf heads as text.
`timescale 1ns/1ps
module result_display
    import result_display_pkg::*;
#(
    parameter  int CLK_HZ  = 100_000_000,
    parameter  int SCAN_HZ = 1000,
    parameter  int DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [31:0]      res_data,
    output logic             res_ready,
    input  logic             next,
    output logic [6:0]       seg,
    output logic [7:0]       an,
    output logic             dp,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int PRE_W    = $clog2(SCAN_DIV);
    localparam int DIG_W    = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [31:0]           mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;

    logic        push, pop, tick, empty;
    logic [31:0] head;
    logic [3:0]  nibble;
    logic [6:0]  hex_seg, glyph;

    // Queue bookkeeping; ready comes from registered count only.
    always_comb begin
        empty      = (count_q == '0);
        push       = res_valid & res_ready;
        pop        = next & ~empty;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        overflow_d = overflow_q | (res_valid & ~res_ready);
    end

    always_comb begin
        tick    = (pre_q == PRE_LAST);
        pre_d   = tick ? '0 : pre_q + PRE_W'(1);
        digit_d = digit_q + DIG_W'(tick);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= res_data;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign nibble = head[{digit_q, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef FLOAT_SPECIAL_TEXT_EN
    // Inf/NaN replace the hex view; unused digits stay enabled but dark.
    always_comb begin
        glyph = hex_seg;
        case (fp_classify(head))
            FP_NAN: begin
                case (digit_q)
                    3'd2:    glyph = GLYPH_n;
                    3'd1:    glyph = GLYPH_A;
                    3'd0:    glyph = GLYPH_n;
                    default: glyph = BLANK;
                endcase
            end
            FP_INF: begin
                case (digit_q)
                    3'd3:    glyph = head[SIGN_BIT] ? DASH : BLANK;
                    3'd2:    glyph = GLYPH_I;
                    3'd1:    glyph = GLYPH_n;
                    3'd0:    glyph = GLYPH_F;
                    default: glyph = BLANK;
                endcase
            end
            default: glyph = hex_seg;
        endcase
    end
`else
    assign glyph = hex_seg;
`endif

    always_comb begin
        seg_d = empty ? BLANK : glyph;
        an_d  = empty ? '1 : ~(NUM_DIGITS'(1) << digit_q);
        dp_d  = ~((count_q > CNT_ONE) && (digit_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pre_q      <= '0;
            digit_q    <= '0;
            seg_q      <= BLANK;
            an_q       <= '1;
            dp_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pre_q      <= pre_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

    assign res_ready = (count_q != CNT_FULL);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_result_display.sv
// Directed scoreboard bench for result_display (SCAN_DIV=4, DEPTH=4).
`timescale 1ns/1ps
module tb_result_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        next;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic [2:0]  count;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    int          cyc;
    logic [31:0] sb [$];
    logic        ovf_model;
    logic [31:0] ovf_words [5];
    logic [31:0] spc_words [3];

    always #5 clk = ~clk;

    result_display #(
        .CLK_HZ  (8),
        .SCAN_HZ (2),
        .DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .next      (next),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .count     (count),
        .overflow  (overflow)
    );

    // Edges since reset release; display at edge e shows digit (e-1)/4.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] exp_glyph(input logic [31:0] w, input int d);
        logic [3:0] nib;
        nib = w[4*d +: 4];
`ifdef FLOAT_SPECIAL_TEXT_EN
        if (w[30:23] == 8'hFF) begin
            if (w[22:0] != 23'd0) begin
                if (d == 2 || d == 0) return 7'h2B;
                if (d == 1) return 7'h08;
                return 7'h7F;
            end
            if (d == 3) return w[31] ? 7'h3F : 7'h7F;
            if (d == 2) return 7'h79;
            if (d == 1) return 7'h2B;
            if (d == 0) return 7'h0E;
            return 7'h7F;
        end
`endif
        return hex7(nib);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_disp(input string tag);
        int         d;
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        d = ((cyc - 1) / 4) % 8;
        if (sb.size() == 0) begin
            ea = 8'hFF;
            es = 7'h7F;
        end else begin
            ea = ~(8'd1 << d);
            es = exp_glyph(sb[0], d);
        end
        ed = !((sb.size() > 1) && (d == 0));
        chk(tag, {16'd0, an, seg, dp}, {16'd0, ea, es, ed});
    endtask

    task automatic scan(input string tag);
        chk({tag, "_count"}, {29'd0, count}, sb.size());
        for (int i = 0; i < 32; i++) begin
            check_disp(tag);
            step();
        end
    endtask

    task automatic push(input logic [31:0] w);
        res_data  = w;
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        if (sb.size() < 4) sb.push_back(w);
        else ovf_model = 1'b1;
        $display("push %h count=%0d", w, sb.size());
    endtask

    task automatic pop();
        next = 1'b1;
        step();
        next = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        $display("pop  count=%0d", sb.size());
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_an"},    {24'd0, an}, 32'hFF);
        chk({tag, "_seg"},   {25'd0, seg}, 32'h7F);
        chk({tag, "_dp"},    {31'd0, dp}, 32'd1);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
        chk({tag, "_ready"}, {31'd0, res_ready}, 32'd1);
        chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        ovf_words = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h40490FDB, 32'hC0000000};
        spc_words = '{32'hFF800000, 32'h7FC00000, 32'h7F800000};
        ovf_model = 1'b0;
        rst = 1'b1; res_valid = 1'b0; res_data = '0; next = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;

        // Single push: full scan of 0x3F800000.
        push(32'h3F800000);
        step();
        scan("single");

        // Pop to empty, then a pop on empty is ignored.
        pop();
        step();
        check_idle("drained");
        pop();
        step();
        check_idle("empty_pop");

        // Five back-to-back strobes: fifth dropped.
        for (int i = 0; i < 5; i++) begin
            chk("ready_before_push", {31'd0, res_ready}, (sb.size() < 4) ? 32'd1 : 32'd0);
            res_data  = ovf_words[i];
            res_valid = 1'b1;
            step();
            if (sb.size() < 4) sb.push_back(ovf_words[i]);
            else ovf_model = 1'b1;
            $display("push %h count=%0d", ovf_words[i], sb.size());
        end
        res_valid = 1'b0;
        chk("full_count", {29'd0, count}, sb.size());
        chk("full_ready", {31'd0, res_ready}, 32'd0);
        chk("overflow_set", {31'd0, overflow}, {31'd0, ovf_model});
        step();
        scan("full");

        // Down to two entries, then push and pop in one cycle.
        pop();
        pop();
        res_data  = 32'h12345678;
        res_valid = 1'b1;
        next      = 1'b1;
        step();
        res_valid = 1'b0;
        next      = 1'b0;
        void'(sb.pop_front());
        sb.push_back(32'h12345678);
        $display("push+pop count=%0d", sb.size());
        chk("simul_count", {29'd0, count}, sb.size());
        step();
        scan("simul");
        chk("overflow_sticky", {31'd0, overflow}, {31'd0, ovf_model});

        // Asynchronous reset between edges clears outputs without a clock.
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        sb.delete();
        ovf_model = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_idle("post_rst");

        // IEEE special values (text with the feature macro, hex otherwise).
        for (int i = 0; i < 3; i++) begin
            push(spc_words[i]);
            step();
            scan("special");
            pop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_display.md
# result_display

Downstream consumer of the floating-point operation unit. Captures each 32-bit result word (compare flag, subtraction, sum, product) as it is produced, queues up to DEPTH results, and shows the head result as 8 hex digits on a multiplexed active-low 7-segment display. A pulse on `next` retires the head result. Sits between the operation unit's result register and the board's display pins.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- SCAN_HZ, 1000, digit-advance rate; SCAN_DIV = CLK_HZ/SCAN_HZ, must be ≥2
- DEPTH, 4, result queue depth, power of 2, ≥2
---
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- res_valid  in  1  one-cycle strobe, res_data valid
- res_data  in  32  result word (IEEE-754 single or 0/1 compare flag)
- res_ready  out  1  queue not full
- next  in  1  debounced single-cycle pulse, pop head
- seg  out  7  active-low segments, seg[6:0] = g f e d c b a
- an  out  8  active-low digit enables, an[k] selects digit k (k=7 leftmost)
- dp  out  1  active-low decimal point
- count  out  $clog2(DEPTH)+1  queue occupancy
- overflow  out  1  sticky, set when a result is dropped

## Operation
- Push: res_valid & res_ready writes res_data at the tail; count+1.
- Push while full: word dropped, overflow←1, held until rst.
- Pop: next & (count≠0) advances the head; count−1. next on empty is ignored, no underflow.
- Simultaneous push and pop: both happen, count unchanged. When full, res_ready is low, so the push is dropped even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.
- Prescaler counts 0..SCAN_DIV−1. On the terminal value, tick asserts and the prescaler returns to 0.
- Digit index 0..7 increments on tick and wraps 7→0.
- Non-empty: digit k shows head[4k+3:4k] in hex. Codes: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Empty: an=8'hFF, seg=7'h7F.
- dp low only on digit 0 when count>1, to flag more results pending.

## Timing
- Reset values: seg=7'h7F, an=8'hFF, dp=1, count=0, overflow=0, res_ready=1, prescaler=0, digit index=0, queue pointers 0.
- Reset is asynchronous. Assertion mid-scan or mid-queue clears everything immediately, and queued results are discarded.
- res_ready is decoded from the registered count, with no combinational path from res_valid or next.
- seg, an and dp are registered and reflect state one cycle after a change of digit index or head.
- A push into an empty queue is displayed from the second rising edge after the strobe.
- A pop shows the new head on the second edge after next.
- Each digit is enabled for exactly SCAN_DIV cycles per scan.

## Configuration
- FLOAT_SPECIAL_TEXT_EN defined:
  - Head with exponent=8'hFF and mantissa≠0 shows "nAn" on digits 2..0; other digits blank.
  - Exponent=8'hFF and mantissa=0 shows "InF" on digits 2..0. Digit 3 shows "-" (0x3F) if the sign is 1, else blank.
  - Blank is 0x7F, and blank digits keep their an bit low.
- Undefined: all values are shown as plain hex, and the decode logic is absent.

## Structure
- Package result_display_pkg holds:
  - the hex segment constants
  - glyphs BLANK, DASH, GLYPH_I, GLYPH_n, GLYPH_A, GLYPH_F
  - NUM_DIGITS=8
  - IEEE field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23
- One combinational sub-module, seg_hex_decode, maps a 4-bit nibble to 7 segment bits.
- Queue, prescaler, scan counter and special-value mux stay in result_display.

## Test plan
Bench uses CLK_HZ=8, SCAN_HZ=2 (SCAN_DIV=4), DEPTH=4.
- Reset: pulse rst between clock edges → outputs go immediately to an=FF, seg=7F, dp=1, count=0, res_ready=1, overflow=0.
- Single push: push 0x3F800000 → an steps FE,FD,…,7F, each held 4 cycles. Segments: digit 7=0x30, digit 6=0x0E, digit 5=0x00, digits 4..0=0x40. dp stays 1.
- Overflow: push 5 words back-to-back → res_ready low after the 4th, 5th dropped, count=4, overflow=1, dp low on digit 0.
- Simultaneous push and pop: push and next in the same cycle at count=2 → count stays 2, display shows the second-pushed word.
- Empty pop: next with count=0 → count 0, an=FF, no state change.
- Special values: with FLOAT_SPECIAL_TEXT_EN, 0xFF800000 → digits 3..0 show "-InF" and 0x7FC00000 → "nAn". Without the macro, 0x7F800000 → hex digits 7,F,8,0,0,0,0,0.
